instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch stage sitting directly upstream of decode. Owns the program counter, issues word reads to instruction memory, and buffers returned instructions with their PCs in a small FIFO. Presents them to decode through a valid/ready handshake. Branch/jump redirects from downstream flush the queue and discard in-flight reads.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset
- IMEM_AW, 8, instruction-memory word-address width (PC bits [IMEM_AW+1:2])

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  read strobe, one word per cycle
- imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
- imem_data  in  32  read data, valid exactly 1 cycle after imem_req
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced 0
- dec_valid  out  1  head entry valid
- dec_ready  in  1  decode accepts head this cycle
- dec_instr  out  32  head instruction; 0 when dec_valid=0
- dec_pc  out  32  head PC; 0 when dec_valid=0
- dec_pc_plus4  out  32  dec_pc+4 mod 2^32; 0 when dec_valid=0
- fetch_pc  out  32  PC of next request (debug/prog_count)

## Operation
- State: fetch_pc, FIFO storage {pc, instr}×DEPTH, rd/wr pointers, count (0..DEPTH), inflight flag, inflight_pc.
- Pop: dec_valid & dec_ready; head advances at the clock edge.
- Issue: imem_req=1 iff rst high, redirect_valid=0, and count + inflight − pop < DEPTH. On issue: inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4 (wraps 0xFFFF_FFFC→0).
- Return: when inflight=1, imem_data is written with inflight_pc at wr pointer; inflight clears unless a new request issues the same cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Redirect (highest priority): count←0, pointers←0, inflight←0 (returning data discarded, not written), fetch_pc←{redirect_pc[31:2],2'b00}. No request issues in the redirect cycle. Any same-cycle pop/push is ignored for state update; the handshake still completes from decode's view.
- The queue never overflows by construction; the credit rule reserves a slot for every in-flight read.
- Reset (async assert, any time): fetch_pc=RESET_PC, count=0, inflight=0, imem_req=0, dec_valid=0, dec_* = 0. Deassertion is synchronised by the surrounding design.

## Timing
- First request: cycle 0 after rst deasserts, address RESET_PC[IMEM_AW+1:2].
- Request in cycle N → data at N+1 → entry written at end of N+1 → dec_valid at N+2. Fetch-to-decode latency is 2 cycles.
- Redirect in cycle R → request to redirect_pc in R+1 → dec_valid at R+3.
- Steady state with dec_ready=1: one instruction per cycle, no bubbles.
- dec_ready low: queue fills to DEPTH, then imem_req drops. Request resumes the same cycle a pop occurs.

## Configuration
- IFQ_BYPASS_EN defined: when count=0 and a return arrives (not squashed), imem_data/inflight_pc drive dec_* combinationally with dec_valid=1. If popped that cycle, the data is not written; otherwise it is written normally. Fetch-to-decode latency becomes 1 cycle; redirect-to-dec_valid becomes R+2.
- Undefined: all dec_* come from FIFO storage only (registered path), with latencies as in Timing.

## Test plan
- Reset release, RESET_PC=0, dec_ready=1, memory word k = 0x1000_0000+k → dec_pc 0,4,8,… from cycle 2, one per cycle, dec_instr 0x1000_0000,0x1000_0001,…; dec_pc_plus4 = dec_pc+4.
- dec_ready=0 for 10 cycles → exactly DEPTH(4) requests issue, then imem_req=0. On dec_ready=1, head stays PC 0 and order is preserved with no gaps or duplicates.
- Redirect to 0x40 in a cycle with a request in flight → stale return not delivered. Next dec_pc=0x40 at R+3 (R+2 with IFQ_BYPASS_EN).
- Redirect with redirect_pc=0x43 and a simultaneous pop → fetch resumes at 0x40 and count=0 after the edge.
- redirect_pc=0xFFFF_FFF8 → dec_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; dec_pc_plus4 of 0xFFFF_FFFC is 0.
- Assert rst mid-stream with the queue full → dec_valid=0, imem_req=0, fetch_pc=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage in front of decode.
// Owns the fetch PC, issues one word read per cycle to instruction memory,
// and queues returned instructions with their PCs for decode (valid/ready).
// A redirect flushes the queue and squashes any read in flight.
// Optional feature: define IFQ_BYPASS_EN to forward a returning word straight
// to decode when the queue is empty (1-cycle fetch-to-decode latency).
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [31:0]        dec_instr,
  output logic [31:0]        dec_pc,
  output logic [31:0]        dec_pc_plus4,
  output logic [31:0]        fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  // PC of the instruction that follows the given one (wraps at 2^32)
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          inflight_r;
  logic [31:0]   inflight_pc_r;
  logic [31:0]   fetch_pc_r;

  logic          nonempty_s;
  logic          bypass_s;
  logic          fifo_pop_s;
  logic          bypass_pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   occ_s;
  logic [31:0]   redirect_aligned_s;

  assign nonempty_s = (count_r != CNT_ZERO);

`ifdef IFQ_BYPASS_EN
  // Forward a returning word when nothing older is queued and it is not squashed
  assign bypass_s = ~nonempty_s & inflight_r & ~redirect_valid;
`else
  assign bypass_s = 1'b0;
`endif

  assign fifo_pop_s   = nonempty_s & dec_ready;
  assign bypass_pop_s = bypass_s & dec_ready;
  // A bypassed word taken by decode this cycle is never written to the queue
  assign push_s       = inflight_r & ~redirect_valid & ~bypass_pop_s;

  // Slots committed after this cycle: queued + in-flight - leaving now.
  // A pop implies count>=1 or a bypassed in-flight word, so no underflow.
  assign occ_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r}
               - {{CW{1'b0}}, (fifo_pop_s | bypass_pop_s)};

  assign issue_s            = rst & ~redirect_valid & (occ_s < DEPTH_C);
  assign imem_req           = issue_s;
  assign imem_addr          = fetch_pc_r[IMEM_AW+1:2];
  assign fetch_pc           = fetch_pc_r;
  assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

  // Decode-side view: queue head, else bypassed return, else all zero
  always_comb begin
    dec_valid    = 1'b0;
    dec_instr    = 32'h0000_0000;
    dec_pc       = 32'h0000_0000;
    dec_pc_plus4 = 32'h0000_0000;
    if (nonempty_s) begin
      dec_valid    = 1'b1;
      dec_instr    = instr_mem_r[rd_ptr_r];
      dec_pc       = pc_mem_r[rd_ptr_r];
      dec_pc_plus4 = next_pc(pc_mem_r[rd_ptr_r]);
    end else if (bypass_s) begin
      dec_valid    = 1'b1;
      dec_instr    = imem_data;
      dec_pc       = inflight_pc_r;
      dec_pc_plus4 = next_pc(inflight_pc_r);
    end else begin
      dec_valid    = 1'b0;
    end
  end

  // Queue storage: capture returning word with its PC at the write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
      instr_mem_r[wr_ptr_r] <= imem_data;
    end
  end

  // Control state: pointers, occupancy, in-flight tracking and fetch PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= CNT_ZERO;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      fetch_pc_r    <= RESET_PC;
    end else if (redirect_valid) begin
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= CNT_ZERO;
      inflight_r    <= 1'b0;
      fetch_pc_r    <= redirect_aligned_s;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, fifo_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= next_pc(fetch_pc_r);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random
// ready/redirect traffic, compared each cycle against a queue-based model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IMEM_AW  = 8;

  logic               clk;
  logic               rst;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [31:0]        dec_instr;
  logic [31:0]        dec_pc;
  logic [31:0]        dec_pc_plus4;
  logic [31:0]        fetch_pc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
    .fetch_pc(fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: queued entries in program order, one optional read in flight
  entry_t      q[$];
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;

  int n_cmp = 0;
  int n_err = 0;

  // Memory contents: word k holds 0x1000_0000 + k
  function automatic logic [31:0] word(input logic [IMEM_AW-1:0] a);
    return 32'h1000_0000 + {{(32-IMEM_AW){1'b0}}, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_infl    = 1'b0;
    m_infl_pc = 32'h0;
    m_fpc     = RESET_PC;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance both
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    int          occ;
    logic        byp, pop_q, exp_v, exp_req, req_seen;
    logic [31:0] ep, ei;
    logic [IMEM_AW-1:0] addr_seen;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    #2;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (q.size() == 0) && m_infl && !rv;
`endif
    if (q.size() > 0) begin
      exp_v = 1'b1; ep = q[0].pc; ei = q[0].instr;
    end else if (byp) begin
      exp_v = 1'b1; ep = m_infl_pc; ei = word(m_infl_pc[IMEM_AW+1:2]);
    end else begin
      exp_v = 1'b0; ep = 32'h0; ei = 32'h0;
    end
    pop_q   = (q.size() > 0) && rdy;
    occ     = q.size() + (m_infl ? 1 : 0) - ((exp_v && rdy) ? 1 : 0);
    exp_req = !rv && (occ < DEPTH);

    check("dec_valid", {31'd0, dec_valid}, {31'd0, exp_v});
    check("dec_pc", dec_pc, ep);
    check("dec_instr", dec_instr, ei);
    check("dec_pc_plus4", dec_pc_plus4, exp_v ? ep + 32'd4 : 32'h0);
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check("imem_addr", {{(32-IMEM_AW){1'b0}}, imem_addr},
          {{(32-IMEM_AW){1'b0}}, m_fpc[IMEM_AW+1:2]});
    check("fetch_pc", fetch_pc, m_fpc);

    req_seen  = imem_req;
    addr_seen = imem_addr;

    if (rv) begin
      q.delete();
      m_infl = 1'b0;
      m_fpc  = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop_q) void'(q.pop_front());
      if (m_infl && !(byp && rdy))
        q.push_back('{pc: m_infl_pc, instr: word(m_infl_pc[IMEM_AW+1:2])});
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    imem_data = req_seen ? word(addr_seen) : 32'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dec_valid"}, {31'd0, dec_valid}, 32'd0);
    check({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_fetch_pc"}, fetch_pc, RESET_PC);
    check({tag, "_dec_pc"}, dec_pc, 32'h0);
    check({tag, "_dec_instr"}, dec_instr, 32'h0);
    check({tag, "_dec_pc_plus4"}, dec_pc_plus4, 32'h0);
  endtask

  initial begin
    rst            = 1'b0;
    imem_data      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    model_reset();
    #2;
    check_reset_state("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Steady streaming
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);

    // Back-pressure then drain
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect with a read in flight
    step(1'b1, 32'h0000_0040, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect with simultaneous pop
    step(1'b1, 32'h0000_0043, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // PC wrap-around
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(rv, rpc, ($urandom_range(0, 3) != 0));
    end

    // Fill the queue, then assert reset between clock edges
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    imem_data = 32'h0;
    rst       = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
